fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch responder driven by the fetch/PC-write strobes of the multi-cycle control counter. On each `if_enable` strobe it performs one request/acknowledge read from instruction memory at the current PC and latches the returned word into the IF/ID instruction register. It owns the PC register and applies `pc_write` updates, deferring them while a fetch is outstanding so the address presented to memory never changes mid-transaction.

## Interface
- `ADDR_WIDTH`, 32, PC and memory address width.
- `DATA_WIDTH`, 32, instruction word width.
- `TIMEOUT`, 15, maximum wait cycles for `imem_ack`, range 1–255; only used with `FETCH_TIMEOUT_EN`.

- `clk` in 1, single clock; all state updates on the rising edge.
- `rst` in 1, asynchronous, active-high reset.
- `if_enable` in 1, fetch strobe, one cycle wide.
- `pc_write` in 1, PC update strobe, one cycle wide.
- `pc_next` in ADDR_WIDTH, next PC value, sampled when `pc_write` is high.
- `pc` out ADDR_WIDTH, current PC register.
- `imem_req` out 1, memory read request.
- `imem_addr` out ADDR_WIDTH, read address, registered.
- `imem_ack` in 1, memory acknowledge; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in DATA_WIDTH, read data.
- `instr` out DATA_WIDTH, latched instruction.
- `instr_valid` out 1, one-cycle pulse when `instr` has been updated.
- `fetch_busy` out 1, high while in state REQ.
- `fetch_error` out 1, sticky timeout flag.

## Operation
- States:
  - **IDLE**: the only state that accepts `if_enable`. On `if_enable`, load `imem_addr <= pc`, raise `imem_req`, clear the wait counter and go to REQ.
  - **REQ**: `imem_req` and `imem_addr` are held stable.
    - On `imem_ack`: `instr <= imem_rdata`, pulse `instr_valid`, drop `imem_req` and return to IDLE.
    - With `FETCH_TIMEOUT_EN`: each cycle without `imem_ack` increments the wait counter.
  - **ERR**: reached only on timeout. Terminal until `rst`.
- `if_enable` while in REQ or ERR is ignored. It is not queued.
- PC update rules:
  - `pc_write` outside REQ: `pc <= pc_next` at that edge.
  - `pc_write` during REQ: `pc_next` is captured into a pending register and a pending flag is set.
  - The pending value is applied at the edge where `imem_ack` completes the fetch.
  - A second `pc_write` during the same REQ overwrites the pending value. Last write wins.
- `if_enable` and `pc_write` together in IDLE: the fetch uses the old `pc`, and `pc` takes `pc_next` at the same edge.
- The PC has no increment logic. `pc_next` comes from the datapath, and wrap-around is the datapath's responsibility.

## Timing
- Reset values:
  - `pc`, `imem_addr`, `instr`: 0.
  - `imem_req`, `instr_valid`, `fetch_busy`, `fetch_error`: 0.
  - State IDLE; pending flag 0; wait counter 0.
- Reset mid-fetch drops `imem_req` immediately (asynchronously). A late `imem_ack` after reset is ignored because the block is in IDLE.
- Fetch latency sequence:
  - `if_enable` sampled at edge N: `imem_req` is high after edge N.
  - Earliest `imem_ack` sampled at edge N+1: `instr` and `instr_valid` are updated after edge N+1, and `imem_req` is low after N+1.
  - The fetch completes in 2 edges. With the 5-cycle control period, memory may insert up to 3 wait cycles without overlapping the next strobe.
- `instr_valid` is high for exactly one cycle per completed fetch. `instr` holds its value until the next completed fetch.
- Timeout:
  - If the wait counter equals `TIMEOUT` at an edge with `imem_ack` low, the block enters ERR.
  - On entering ERR: `fetch_error` is set, `instr` is cleared to 0 (NOP), `imem_req` is dropped, and no `instr_valid` is issued.
  - The pending PC is discarded.
  - If `imem_ack` arrives at the same edge as the timeout, the acknowledge wins.

## Configuration
- `FETCH_TIMEOUT_EN` defined: the wait counter, the ERR state and the timeout behaviour are compiled in.
- `FETCH_TIMEOUT_EN` undefined: REQ waits indefinitely for `imem_ack`, the ERR state is unreachable, and `fetch_error` is tied to 0.

## Test plan
- Reset, then hold `pc_next`=0x40 and pulse `pc_write`, then pulse `if_enable`:
  - `imem_addr`=0x40 and `imem_req`=1.
  - With `imem_ack` one cycle later and `imem_rdata`=0xDEADBEEF: `instr`=0xDEADBEEF and `instr_valid` high for 1 cycle.
- Drive `imem_ack` 3 cycles late and pulse `pc_write` (`pc_next`=0x44) during REQ:
  - `imem_addr` stays 0x40 throughout.
  - `pc` becomes 0x44 at the ack edge.
- Pulse `if_enable` and `pc_write` (`pc_next`=0x48) together in IDLE with `pc`=0x44:
  - `imem_addr`=0x44 and `pc`=0x48.
- Pulse `if_enable` again during REQ: no second request, and exactly one `instr_valid`.
- With `FETCH_TIMEOUT_EN` and TIMEOUT=15, never acknowledge:
  - `fetch_error`=1, `instr`=0 and `imem_req`=0.
  - Later `if_enable` strobes are ignored.
  - Assert `rst`: all outputs return to 0.
- With `FETCH_TIMEOUT_EN` and TIMEOUT=15, acknowledge exactly at the timeout edge: a normal completion, `fetch_error`=0.

Source files
------------

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module      : fetch_unit
//  Description : Request/acknowledge instruction fetch responder that owns the
//                PC register. Optional timeout via FETCH_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_enable,
    input  logic                  pc_write,
    input  logic [ADDR_WIDTH-1:0] pc_next,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic                  fetch_busy,
    output logic                  fetch_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_start;
    logic                  w_done;
    logic                  w_timeout;

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [DATA_WIDTH-1:0] r_instr;
    logic                  r_instr_valid;
    logic                  r_pend_valid;
    logic [ADDR_WIDTH-1:0] r_pend_pc;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] c_timeout = 8'(TIMEOUT);
    logic [7:0]            r_wait_cnt;
    logic                  r_fetch_error;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (if_enable) begin
                    w_state_next = REQ;
                    w_start      = 1'b1;
                end
            end
            REQ: begin
                // An acknowledge on the timeout edge still completes the fetch.
                if (imem_ack) begin
                    w_state_next = IDLE;
                    w_done       = 1'b1;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (r_wait_cnt == c_timeout) begin
                    w_state_next = ERR;
                    w_timeout    = 1'b1;
                end
`endif
            end
            ERR:     w_state_next = ERR;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= '0;
            r_imem_addr   <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_pc     <= '0;
        end else begin
            r_instr_valid <= w_done;
            if (w_start) begin
                r_imem_addr <= r_pc;
            end
            if (w_done) begin
                r_instr <= imem_rdata;
            end else if (w_timeout) begin
                r_instr <= '0;
            end
            // PC writes are deferred while a fetch is outstanding; last write wins.
            if (r_state == REQ) begin
                if (w_done) begin
                    if (pc_write) begin
                        r_pc <= pc_next;
                    end else if (r_pend_valid) begin
                        r_pc <= r_pend_pc;
                    end
                    r_pend_valid <= 1'b0;
                end else if (w_timeout) begin
                    r_pend_valid <= 1'b0;
                end else if (pc_write) begin
                    r_pend_valid <= 1'b1;
                    r_pend_pc    <= pc_next;
                end
            end else if (pc_write) begin
                r_pc <= pc_next;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt    <= 8'd0;
            r_fetch_error <= 1'b0;
        end else begin
            if (w_start) begin
                r_wait_cnt <= 8'd0;
            end else if (r_state == REQ && !imem_ack && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (w_timeout) begin
                r_fetch_error <= 1'b1;
            end
        end
    end

    assign fetch_error = r_fetch_error;
`else
    assign fetch_error = 1'b0;
`endif

    assign pc          = r_pc;
    assign imem_addr   = r_imem_addr;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign imem_req    = (r_state == REQ);
    assign fetch_busy  = (r_state == REQ);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed and randomized bench for fetch_unit with a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam int c_tmo = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_enable;
    logic        pc_write;
    logic [31:0] pc_next;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_busy;
    logic        fetch_error;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    fetch_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (c_tmo)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_enable   (if_enable),
        .pc_write    (pc_write),
        .pc_next     (pc_next),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_busy  (fetch_busy),
        .fetch_error (fetch_error)
    );

    always #5 clk = ~clk;

    // Reference model: one outstanding fetch, a deferred PC write, a wait count.
    bit          m_busy;
    bit          m_err;
    bit          m_valid;
    bit          m_pend;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic [31:0] m_instr;
    logic [31:0] m_pendv;
    int          m_waited;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0; m_err <= 0; m_valid <= 0; m_pend <= 0;
            m_pc <= 0; m_addr <= 0; m_instr <= 0; m_pendv <= 0; m_waited <= 0;
        end else begin
            m_valid <= 0;
            if (!m_busy) begin
                if (if_enable && !m_err) begin
                    m_busy   <= 1;
                    m_addr   <= m_pc;
                    m_waited <= 0;
                end
                if (pc_write) m_pc <= pc_next;
            end else if (imem_ack) begin
                m_busy  <= 0;
                m_instr <= imem_rdata;
                m_valid <= 1;
                m_pend  <= 0;
                if (pc_write)    m_pc <= pc_next;
                else if (m_pend) m_pc <= m_pendv;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (m_waited == c_tmo) begin
                m_busy  <= 0;
                m_err   <= 1;
                m_instr <= 0;
                m_pend  <= 0;
            end
`endif
            else begin
                m_waited <= m_waited + 1;
                if (pc_write) begin
                    m_pend  <= 1;
                    m_pendv <= pc_next;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en && !rst) begin
            chk("pc",          pc,                  m_pc);
            chk("imem_addr",   imem_addr,           m_addr);
            chk("instr",       instr,               m_instr);
            chk("instr_valid", 32'(instr_valid),    32'(m_valid));
            chk("imem_req",    32'(imem_req),       32'(m_busy));
            chk("fetch_busy",  32'(fetch_busy),     32'(m_busy));
            chk("fetch_error", 32'(fetch_error),    32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; if_enable = 0; pc_write = 0; pc_next = 0; imem_ack = 0; imem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", pc, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_instr", instr, 0);
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_busy", 32'(fetch_busy), 0);
        chk("rst_err", 32'(fetch_error), 0);
        rst = 0;
        check_en = 1;

        // Basic fetch from 0x40
        pc_next = 32'h40; pc_write = 1; tick(); pc_write = 0;
        chk("pc_40", pc, 32'h40);
        if_enable = 1; tick(); if_enable = 0;
        chk("addr_40", imem_addr, 32'h40);
        chk("req_hi", 32'(imem_req), 1);
        imem_ack = 1; imem_rdata = 32'hDEADBEEF; tick(); imem_ack = 0;
        chk("instr_dbef", instr, 32'hDEADBEEF);
        chk("valid_pulse", 32'(instr_valid), 1);
        chk("req_lo", 32'(imem_req), 0);
        chk("model_instr", m_instr, 32'hDEADBEEF);
        tick();
        chk("valid_drop", 32'(instr_valid), 0);

        // Three wait cycles, deferred PC write, ignored second strobe
        if_enable = 1; tick(); if_enable = 0;
        pc_next = 32'h44; pc_write = 1; tick(); pc_write = 0;
        chk("pc_deferred", pc, 32'h40);
        chk("addr_hold1", imem_addr, 32'h40);
        if_enable = 1; tick(); if_enable = 0;
        chk("addr_hold2", imem_addr, 32'h40);
        chk("req_hold", 32'(imem_req), 1);
        tick();
        imem_ack = 1; imem_rdata = 32'h12345678; tick(); imem_ack = 0;
        chk("pc_44", pc, 32'h44);
        chk("model_pc", m_pc, 32'h44);
        chk("instr_1234", instr, 32'h12345678);
        tick();
        chk("no_second_req", 32'(imem_req), 0);

        // Fetch and PC write together in IDLE
        if_enable = 1; pc_write = 1; pc_next = 32'h48; tick(); if_enable = 0; pc_write = 0;
        chk("addr_44", imem_addr, 32'h44);
        chk("pc_48", pc, 32'h48);
        imem_ack = 1; imem_rdata = 32'h0BADF00D; tick(); imem_ack = 0;

        // Reset in the middle of a fetch, then a late acknowledge
        if_enable = 1; tick(); if_enable = 0;
        chk("req_before_rst", 32'(imem_req), 1);
        rst = 1; #1;
        chk("req_async_drop", 32'(imem_req), 0);
        tick();
        rst = 0; imem_ack = 1; imem_rdata = 32'h55; tick(); imem_ack = 0;
        chk("late_ack_valid", 32'(instr_valid), 0);
        chk("late_ack_instr", instr, 0);

`ifdef FETCH_TIMEOUT_EN
        if_enable = 1; tick(); if_enable = 0;
        repeat (c_tmo) tick();
        chk("pre_tmo_busy", 32'(fetch_busy), 1);
        tick();
        chk("tmo_err", 32'(fetch_error), 1);
        chk("tmo_instr", instr, 0);
        chk("tmo_req", 32'(imem_req), 0);
        if_enable = 1; tick(); if_enable = 0;
        chk("err_ignores_if", 32'(imem_req), 0);
        rst = 1; #1;
        chk("rst_err_clr", 32'(fetch_error), 0);
        chk("rst_req_clr", 32'(imem_req), 0);
        tick(); rst = 0;
        if_enable = 1; tick(); if_enable = 0;
        repeat (c_tmo) tick();
        imem_ack = 1; imem_rdata = 32'hCAFEF00D; tick(); imem_ack = 0;
        chk("edge_ack_err", 32'(fetch_error), 0);
        chk("edge_ack_instr", instr, 32'hCAFEF00D);
        chk("edge_ack_valid", 32'(instr_valid), 1);
`endif

        // Randomized traffic; acks never coincide with a PC write, no timeouts
        for (int i = 0; i < 3000; i++) begin
            if (rst) rst = 0;
            else if ($urandom_range(0, 299) == 0) rst = 1;
            imem_ack   = m_busy ? (($urandom_range(0, 2) == 0) || m_waited >= 10)
                                : ($urandom_range(0, 7) == 0);
            imem_rdata = $urandom;
            if_enable  = ($urandom_range(0, 3) == 0);
            pc_write   = !imem_ack && ($urandom_range(0, 2) == 0);
            pc_next    = $urandom;
            tick();
        end
        rst = 0; if_enable = 0; pc_write = 0; imem_ack = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
